// File: rtl/cla_arb_pkg.sv
// Shared types and defaults for the CLA arbiter slice.
package cla_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned CLA_ARB_WIDTH = 16;
   localparam int unsigned CLA_ARB_NREQ  = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin grant selection: search starts one past the last granted
// requester and wraps modulo NREQ. The grant is one-hot and only asserted
// while enabled; grant_idx always reports the winner of the search.
module rr_arbiter
   import cla_arb_pkg::*;
#(
   parameter int unsigned NREQ = CLA_ARB_NREQ,
   parameter int unsigned IDW  = $clog2(NREQ)
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  last_grant,
   input  logic            en,
   output logic [NREQ-1:0] grant,
   output logic [IDW-1:0]  grant_idx
);

   logic           found;
   int unsigned    cand;
   logic [IDW-1:0] cand_idx;

   // Rotating priority search, first valid requester after last_grant wins
   always_comb begin
      grant     = '0;
      grant_idx = last_grant;
      found     = 1'b0;
      cand      = 0;
      cand_idx  = '0;
      for (int unsigned k = 1; k <= NREQ; k++) begin
         cand     = (32'(last_grant) + k) % NREQ;
         cand_idx = IDW'(cand);
         if (!found && req[cand_idx]) begin
            found     = 1'b1;
            grant_idx = cand_idx;
         end
      end
      if (en && found) begin
         grant[grant_idx] = 1'b1;
      end
   end

endmodule

// File: rtl/cla_arbiter.sv
// Arbitrates NREQ requesters onto one shared external carry-lookahead adder.
// One operation at a time: IDLE -> CALC (operands presented) -> RESP (result
// held until consumed). A new request may be accepted in the same cycle the
// result is consumed, giving one result every two cycles.
// Optional feature: define CLA_ARB_STATS_EN to add the saturating ovf_cnt
// output counting results captured with carry-out set.
module cla_arbiter
   import cla_arb_pkg::*;
#(
   parameter int unsigned WIDTH = CLA_ARB_WIDTH,
   parameter int unsigned NREQ  = CLA_ARB_NREQ
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NREQ-1:0]           req_valid,
   output logic [NREQ-1:0]           req_ready,
   input  logic [NREQ*WIDTH-1:0]     req_a,
   input  logic [NREQ*WIDTH-1:0]     req_b,
   output logic [WIDTH-1:0]          add_a,
   output logic [WIDTH-1:0]          add_b,
   input  logic [WIDTH:0]            add_z,
   output logic                      rsp_valid,
   input  logic                      rsp_ready,
   output logic [WIDTH:0]            rsp_z,
   output logic [$clog2(NREQ)-1:0]   rsp_id,
   output logic                      busy
`ifdef CLA_ARB_STATS_EN
   ,
   output logic [7:0]                ovf_cnt
`endif
);

   localparam int unsigned IDW = $clog2(NREQ);

   state_t             state_q, state_d;
   logic [IDW-1:0]     last_grant_q, last_grant_d;
   logic [WIDTH-1:0]   op_a_q, op_a_d;
   logic [WIDTH-1:0]   op_b_q, op_b_d;
   logic [IDW-1:0]     op_id_q, op_id_d;
   logic [WIDTH:0]     rsp_z_q, rsp_z_d;
   logic [IDW-1:0]     rsp_id_q, rsp_id_d;

   logic               arb_en;
   logic [NREQ-1:0]    grant;
   logic [IDW-1:0]     grant_idx;
   logic               hs;

   // Accept window: idle, or result being consumed this cycle; never in reset
   always_comb begin
      arb_en = rst_n && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));
   end

   rr_arbiter #(
      .NREQ (NREQ),
      .IDW  (IDW)
   ) u_rr_arbiter (
      .req        (req_valid),
      .last_grant (last_grant_q),
      .en         (arb_en),
      .grant      (grant),
      .grant_idx  (grant_idx)
   );

   assign hs        = |grant;
   assign req_ready = grant;
   assign add_a     = op_a_q;
   assign add_b     = op_b_q;
   assign rsp_valid = (state_q == RESP);
   assign busy      = (state_q != IDLE);
   assign rsp_z     = rsp_z_q;
   assign rsp_id    = rsp_id_q;

   // Next-state, operand capture on handshake, result capture in CALC
   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      op_id_d      = op_id_q;
      rsp_z_d      = rsp_z_q;
      rsp_id_d     = rsp_id_q;
      case (state_q)
         IDLE: begin
            if (hs) state_d = CALC;
         end
         CALC: begin
            rsp_z_d  = add_z;
            rsp_id_d = op_id_q;
            state_d  = RESP;
         end
         RESP: begin
            if (rsp_ready) state_d = hs ? CALC : IDLE;
         end
         default: state_d = IDLE;
      endcase
      if (hs) begin
         last_grant_d = grant_idx;
         op_a_d       = req_a[32'(grant_idx)*WIDTH +: WIDTH];
         op_b_d       = req_b[32'(grant_idx)*WIDTH +: WIDTH];
         op_id_d      = grant_idx;
      end
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         last_grant_q <= IDW'(NREQ - 1);
         op_a_q       <= '0;
         op_b_q       <= '0;
         op_id_q      <= '0;
         rsp_z_q      <= '0;
         rsp_id_q     <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         op_id_q      <= op_id_d;
         rsp_z_q      <= rsp_z_d;
         rsp_id_q     <= rsp_id_d;
      end
   end

`ifdef CLA_ARB_STATS_EN
   logic [7:0] ovf_cnt_q, ovf_cnt_d;

   // Saturating count of results captured with carry-out set
   always_comb begin
      ovf_cnt_d = ovf_cnt_q;
      if ((state_q == CALC) && add_z[WIDTH] && (ovf_cnt_q != '1)) begin
         ovf_cnt_d = ovf_cnt_q + 8'd1;
      end
   end

   // Overflow counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ovf_cnt_q <= '0;
      else        ovf_cnt_q <= ovf_cnt_d;
   end

   assign ovf_cnt = ovf_cnt_q;
`endif

endmodule
